// File: rtl/fpu_arbiter_if.sv
// Requester/FPU handshake bundle for fpu_arbiter: two request ports, the
// FPU issue/return path and the per-port response.
interface fpu_arbiter_if #(
    parameter int unsigned TAG_W = 5
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [31:0]      req_a0;
    logic [31:0]      req_a1;
    logic [31:0]      req_b0;
    logic [31:0]      req_b1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;

    logic             fpu_start;
    logic [3:0]       fpu_op;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic             fpu_valid;
    logic [31:0]      fpu_result;

    logic [1:0]       done;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             err;
    logic             busy;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               req_tag0, req_tag1, fpu_valid, fpu_result,
        output req_ready, fpu_start, fpu_op, fpu_a, fpu_b,
               done, rsp_result, rsp_tag, err, busy
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               req_tag0, req_tag1, fpu_valid, fpu_result,
        input  req_ready, fpu_start, fpu_op, fpu_a, fpu_b,
               done, rsp_result, rsp_tag, err, busy
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Two-port round-robin arbiter in front of a single shared FPU.
// Optional WAIT-state watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_arbiter #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic           CLK,
    input  logic           reset,
    fpu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             rr;
    logic             owner;
    logic [TAG_W-1:0] tag_q;
    logic             any_valid;
    logic             gnt_port;

`ifdef FPU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
    logic [7:0] wd;
    logic       err_q;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Priority goes to rr only under contention; a lone requester always wins.
    always_comb begin
        any_valid     = |bus.req_valid;
        gnt_port      = (bus.req_valid == 2'b11) ? rr : bus.req_valid[1];
        bus.req_ready = '0;
        if (state == IDLE && any_valid)
            bus.req_ready = gnt_port ? 2'b10 : 2'b01;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= IDLE;
            rr             <= 1'b0;
            owner          <= 1'b0;
            tag_q          <= '0;
            bus.fpu_start  <= 1'b0;
            bus.fpu_op     <= '0;
            bus.fpu_a      <= '0;
            bus.fpu_b      <= '0;
            bus.done       <= '0;
            bus.rsp_result <= '0;
            bus.rsp_tag    <= '0;
            bus.busy       <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            wd             <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            bus.fpu_start <= 1'b0;
            bus.done      <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner         <= gnt_port;
                        rr            <= ~gnt_port;
                        bus.fpu_op    <= gnt_port ? bus.req_op1  : bus.req_op0;
                        bus.fpu_a     <= gnt_port ? bus.req_a1   : bus.req_a0;
                        bus.fpu_b     <= gnt_port ? bus.req_b1   : bus.req_b0;
                        tag_q         <= gnt_port ? bus.req_tag1 : bus.req_tag0;
                        bus.fpu_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef FPU_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                WAIT: begin
                    // A completion in the limit cycle takes precedence over the timeout.
                    if (bus.fpu_valid) begin
                        bus.rsp_result <= bus.fpu_result;
                        bus.rsp_tag    <= tag_q;
                        bus.done       <= owner ? 2'b10 : 2'b01;
                        state          <= RESP;
`ifdef FPU_TIMEOUT_EN
                        err_q          <= 1'b0;
                    end else if (wd == TMO_LAST) begin
                        bus.rsp_result <= '0;
                        bus.rsp_tag    <= tag_q;
                        bus.done       <= owner ? 2'b10 : 2'b01;
                        err_q          <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wd <= wd + 8'd1;
`endif
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
`ifdef FPU_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
